adder_tree_seq_ctrl: RTL
========================

Name: adder_tree_seq_ctrl

Overview:
- Sequencing controller for the TLUT product reduction path.
- Accepts one row-slice of the TLUT product matrix per beat over a valid/ready handshake.
- Accumulates DIM_K slices lane-wise into DIM_A accumulators, then presents the reduced multiplication result over a valid/ready output handshake.
- Replaces the one-shot combinational reduction with a time-multiplexed, back-pressurable pipeline stage between the TLUT product generator and the result writeback.

Parameters:
- DIM_A, 4, number of output lanes (accumulators).
- DIM_K, 4, nominal beats (product slices) per tile.
- ACC_WIDTH, 16, accumulator and product element width, unsigned.
- CNT_W, $clog2(DIM_K+1), beat-counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  product slice valid.
- in_ready  output  1  controller can accept a slice.
- in_prod  input  DIM_A*ACC_WIDTH  slice; lane j at bits [j*ACC_WIDTH +: ACC_WIDTH].
- in_last  input  1  qualifies the beat as the final beat of the tile (early termination).
- abort  input  1  synchronous tile discard.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_mult  output  DIM_A*ACC_WIDTH  accumulated result, same lane packing as in_prod.
- out_beats  output  CNT_W  number of beats accumulated into out_mult.
- out_ovf  output  1  sticky: some lane carried out of ACC_WIDTH during this tile.
- busy  output  1  high in ACC or OUT state.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, in_ready=0 during reset then 1 in IDLE, out_valid=0, out_mult=0, out_beats=0, out_ovf=0, busy=0.
- States:
  - IDLE: in_ready=1.
  - ACC: in_ready=1.
  - OUT: in_ready=0, out_valid=1.
- Beat acceptance: a beat is accepted when in_valid&&in_ready.
- IDLE, beat accepted:
  - acc[j] <= in_prod[j] (load, not add); cnt <= 1; ovf <= 0.
  - If in_last or DIM_K==1, go to OUT; else go to ACC.
- ACC, beat accepted:
  - acc[j] <= acc[j] + in_prod[j], modulo 2^ACC_WIDTH.
  - ovf |= OR over lanes of the carry-out; cnt <= cnt+1.
  - If in_last or cnt==DIM_K-1, go to OUT.
  - No beat accepted: hold all state.
- OUT:
  - out_mult = acc, out_beats = cnt, out_ovf = ovf.
  - These are registered and stable while out_valid&&!out_ready.
  - On out_valid&&out_ready, go to IDLE the next cycle.
  - Values remain on the outputs but are not valid afterwards.
- Latency:
  - Result is visible the cycle after the last beat is accepted.
  - Minimum tile period is DIM_K+1 cycles (no overlap of OUT with the next tile's first beat).
- in_last in IDLE: a 1-beat tile; out_beats=1.
- in_last ignored in OUT, since no beat is accepted there.
- abort (highest priority after reset):
  - Any state goes to IDLE the next cycle; out_valid drops; the in-flight beat that cycle is discarded; cnt=0, ovf=0.
  - abort in IDLE is a no-op apart from clearing cnt/ovf.
- Reset mid-tile: same as abort, and all outputs return to their reset values.
- Simultaneous out_ready and in_valid in OUT: only the result handshake completes. The input beat waits (in_ready=0) and is accepted in IDLE on the following cycle.
- Input stability rule: in_prod/in_last must stay stable while in_valid&&!in_ready.
- No combinational path from in_valid to in_ready. out_valid depends only on state.

Test Plan:
- Nominal tile: 4 beats, lanes {1,2,3,4}, {10,20,30,40}, {100,0,0,0}, {0,0,0,1000}, out_ready=1 -> out_valid on cycle 5, out_mult={111,22,33,1044}, out_beats=4, out_ovf=0, back to IDLE.
- Backpressure:
  - out_ready=0 for 3 cycles after the result -> out_mult/out_beats held constant and in_ready=0 throughout.
  - A second tile starts only after the handshake, and its first beat loads (acc equals the new beat, with no residue from the previous tile).
- Early termination: beat {5,5,5,5}, then {1,1,1,1} with in_last=1 -> out_mult={6,6,6,6}, out_beats=2. A single beat with in_last in IDLE -> out_beats=1.
- Wrap/overflow: lane0 beats 0xFFFF then 0x0002 -> lane0=0x0001, out_ovf=1. The next tile without carry shows out_ovf=0.
- Abort/reset mid-tile:
  - abort after 2 beats -> out_valid never asserted; the next 4-beat tile of all-ones gives {4,4,4,4}.
  - rst_n=0 in OUT -> out_valid=0 and out_mult=0 next cycle.
- Gapped input: in_valid toggling 1,0,1,0 -> only handshaked beats are counted, with out_beats=4 and correct sums.

Source files
------------

// File: rtl/adder_tree_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_seq_ctrl
// Description : Lane-wise beat accumulator with valid/ready in/out handshakes.
// Revision    : 1.0
// ============================================================================
module adder_tree_seq_ctrl #(
    parameter int DIM_A     = 4,
    parameter int DIM_K     = 4,
    parameter int ACC_WIDTH = 16,
    parameter int CNT_W     = $clog2(DIM_K + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIM_A*ACC_WIDTH-1:0] in_prod,
    input  logic                       in_last,
    input  logic                       abort,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIM_A*ACC_WIDTH-1:0] out_mult,
    output logic [CNT_W-1:0]           out_beats,
    output logic                       out_ovf,
    output logic                       busy
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_ACC  = 2'd1;
    localparam logic [1:0] C_OUT  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 rdy_q, rdy_d;
    logic [ACC_WIDTH-1:0] acc_q [DIM_A];
    logic [ACC_WIDTH-1:0] acc_d [DIM_A];

    logic [ACC_WIDTH-1:0] w_lane  [DIM_A];
    logic [ACC_WIDTH:0]   w_sum   [DIM_A];
    logic [DIM_A-1:0]     w_carry;
    logic                 w_accept;

    generate
        for (genvar j = 0; j < DIM_A; j++) begin : g_lane
            assign w_lane[j]  = in_prod[j*ACC_WIDTH +: ACC_WIDTH];
            assign w_sum[j]   = {1'b0, acc_q[j]} + {1'b0, w_lane[j]};
            assign w_carry[j] = w_sum[j][ACC_WIDTH];
            assign out_mult[j*ACC_WIDTH +: ACC_WIDTH] = acc_q[j];
        end
    endgenerate

    // in_ready is a flop so it never depends combinationally on in_valid.
    assign w_accept  = in_valid && rdy_q;
    assign in_ready  = rdy_q;
    assign out_valid = (state_q == C_OUT);
    assign busy      = (state_q == C_ACC) || (state_q == C_OUT);
    assign out_beats = cnt_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        acc_d   = acc_q;
        if (abort) begin
            state_d = C_IDLE;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                C_IDLE: begin
                    if (w_accept) begin
                        acc_d   = w_lane;
                        cnt_d   = CNT_W'(1);
                        ovf_d   = 1'b0;
                        state_d = (in_last || (DIM_K == 1)) ? C_OUT : C_ACC;
                    end
                end
                C_ACC: begin
                    if (w_accept) begin
                        for (int j = 0; j < DIM_A; j++) begin
                            acc_d[j] = w_sum[j][ACC_WIDTH-1:0];
                        end
                        ovf_d = ovf_q | (|w_carry);
                        cnt_d = cnt_q + CNT_W'(1);
                        if (in_last || (cnt_q == CNT_W'(DIM_K - 1))) begin
                            state_d = C_OUT;
                        end
                    end
                end
                C_OUT: begin
                    if (out_ready) begin
                        state_d = C_IDLE;
                    end
                end
                default: state_d = C_IDLE;
            endcase
        end
        rdy_d = (state_d != C_OUT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
            for (int j = 0; j < DIM_A; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
            acc_q   <= acc_d;
        end
    end

endmodule
`default_nettype wire
